layer_mac_scheduler: RTL

//  Time-multiplexes one 12x12->23-bit multiplier and an internal accumulator across N_NEURONS neurons of one layer.

---
 rtl/layer_mac_scheduler.sv | 131 +++++++++++++
 1 files changed

// File: rtl/layer_mac_scheduler.sv
// Layer MAC scheduler: shares one external multiplier across all neurons of a layer, bias + dot product + ReLU.
// Optional SCHED_SATURATE_EN: accumulator adds clamp on signed overflow instead of wrapping.
module layer_mac_scheduler #(
    parameter int N_INPUTS  = 3,
    parameter int N_NEURONS = 4,
    parameter int DATA_W    = 12,
    parameter int ACC_W     = 23,
    localparam int XA_W = (N_INPUTS  > 1) ? $clog2(N_INPUTS)  : 1,
    localparam int NA_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    localparam int WA_W = (N_INPUTS*N_NEURONS > 1) ? $clog2(N_INPUTS*N_NEURONS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              x_wr_en,
    input  logic [XA_W-1:0]   x_wr_addr,
    input  logic [DATA_W-1:0] x_wr_data,
    output logic [WA_W-1:0]   w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [NA_W-1:0]   b_addr,
    input  logic [ACC_W-1:0]  b_data,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    input  logic [ACC_W-1:0]  mul_p,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [NA_W-1:0]   y_idx,
    output logic [ACC_W-1:0]  y_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ACC   = 3'd2;
    localparam logic [2:0] S_OUT   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [XA_W-1:0] K_LAST = XA_W'(N_INPUTS - 1);
    localparam logic [NA_W-1:0] N_LAST = NA_W'(N_NEURONS - 1);

    logic [2:0]        state;
    logic [NA_W-1:0]   n;
    logic [XA_W-1:0]   k;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nxt;
    logic [ACC_W-1:0]  addend;
    logic [DATA_W-1:0] x_mem [N_INPUTS];
    logic [31:0]       k_off;

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign y_valid = (state == S_OUT);
    assign y_idx   = n;
    assign y_data  = acc[ACC_W-1] ? '0 : acc;
    assign b_addr  = n;

    // Address runs one step ahead of k so the sync ROM delivers w[k] during ACC step k.
    always_comb begin
        k_off = 32'd0;
        if (state == S_ACC)
            k_off = (k == K_LAST) ? 32'(k) : 32'(k) + 32'd1;
    end
    assign w_addr = WA_W'(32'(n) * N_INPUTS + k_off);

    assign mul_a = (state == S_ACC) ? x_mem[k] : '0;
    assign mul_b = (state == S_ACC) ? w_data   : '0;

    assign addend = (k == '0) ? b_data : acc;

`ifdef SCHED_SATURATE_EN
    logic [ACC_W:0] sum_ext;
    always_comb begin
        sum_ext = {addend[ACC_W-1], addend} + {mul_p[ACC_W-1], mul_p};
        acc_nxt = sum_ext[ACC_W-1:0];
        if (sum_ext[ACC_W] != sum_ext[ACC_W-1])
            acc_nxt = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    assign acc_nxt = addend + mul_p;
`endif

    // Input buffer is not reset and is frozen for the whole pass.
    always_ff @(posedge clk) begin
        if (x_wr_en && state == S_IDLE && 32'(x_wr_addr) < N_INPUTS)
            x_mem[x_wr_addr] <= x_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            n     <= '0;
            k     <= '0;
            acc   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state <= S_FETCH;
                    n     <= '0;
                end
                S_FETCH: begin
                    k     <= '0;
                    state <= S_ACC;
                end
                S_ACC: begin
                    acc <= acc_nxt;
                    if (k == K_LAST) begin
                        k     <= '0;
                        state <= S_OUT;
                    end else begin
                        k <= k + XA_W'(1);
                    end
                end
                S_OUT: if (y_ready) begin
                    if (n == N_LAST) begin
                        state <= S_DONE;
                    end else begin
                        n     <= n + NA_W'(1);
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    n     <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
